// File: rtl/grid_row_scanner.sv
// Double-buffered 8x8 grid receiver that scans the displayed generation one row at a time.
// Define GRID_SCAN_BLANK_EN to insert BLANK dark cycles after every row.
module grid_row_scanner #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  output logic        grid_ready,
  input  logic        scan_en,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic        scanning
);

  if (DWELL < 1 || DWELL > 255 || BLANK < 1 || BLANK > 15) begin : g_bad_param
    $error("grid_row_scanner: DWELL or BLANK out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN
`ifdef GRID_SCAN_BLANK_EN
    , S_BLANK
`endif
  } state_t;

  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);
`ifdef GRID_SCAN_BLANK_EN
  localparam logic [7:0] BL_LAST = 8'(BLANK - 1);
`endif

  state_t      state, nxt_state;
  logic [63:0] display, nxt_disp;
  logic [63:0] pending, nxt_pend;
  logic        pend_full, nxt_pfull;
  logic [2:0]  row, nxt_row;
  logic [7:0]  cnt, nxt_cnt;
  logic        accept;
  logic [7:0][7:0] rows;

  // rows[7] is grid row 0 (top), so row r lives at rows[~r]
  assign rows       = display;
  assign grid_ready = !pend_full;
  assign scanning   = (state != S_IDLE);
  assign accept     = grid_valid && !pend_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      display   <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      row       <= '0;
      cnt       <= '0;
    end else begin
      state     <= nxt_state;
      display   <= nxt_disp;
      pending   <= nxt_pend;
      pend_full <= nxt_pfull;
      row       <= nxt_row;
      cnt       <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_disp   = display;
    nxt_pend   = pending;
    nxt_pfull  = pend_full;
    nxt_row    = row;
    nxt_cnt    = cnt;
    row_sel    = '0;
    col_data   = '0;
    frame_done = 1'b0;

    // the first grid bypasses the pending buffer so the display lights immediately
    if (accept) begin
      if (state == S_IDLE) begin
        nxt_disp  = grid_in;
        nxt_state = S_SCAN;
      end else begin
        nxt_pend  = grid_in;
        nxt_pfull = 1'b1;
      end
    end

    if (scan_en) begin
      case (state)
        S_SCAN: begin
          row_sel  = 8'b1 << row;
          col_data = rows[~row];
          nxt_cnt  = cnt + 8'd1;
          if (cnt == DW_LAST) begin
            nxt_cnt = '0;
`ifdef GRID_SCAN_BLANK_EN
            nxt_state = S_BLANK;
`else
            nxt_row = row + 3'd1;
`endif
            // accept needs pend_full==0, so it can never collide with this swap
            if (row == 3'd7) begin
              frame_done = 1'b1;
              if (pend_full) begin
                nxt_disp  = pending;
                nxt_pfull = 1'b0;
              end
            end
          end
        end
`ifdef GRID_SCAN_BLANK_EN
        S_BLANK: begin
          nxt_cnt = cnt + 8'd1;
          if (cnt == BL_LAST) begin
            nxt_cnt   = '0;
            nxt_row   = row + 3'd1;
            nxt_state = S_SCAN;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
